// File: rtl/maze_move_engine_if.sv
// Key strobe and wall-map read port shared by maze_move_engine and its host.
// The host side (master) drives keys and map data; the engine side (slave) drives the address.
interface maze_move_engine_if #(
    parameter int COORD_W = 6
);
    logic               KEY_STB;
    logic [7:0]         KEY_CODE;
    logic [COORD_W-1:0] WALL_X;
    logic [COORD_W-1:0] WALL_Y;
    logic               WALL_Q;

    modport master (
        output KEY_STB, KEY_CODE, WALL_Q,
        input  WALL_X, WALL_Y
    );

    modport slave (
        input  KEY_STB, KEY_CODE, WALL_Q,
        output WALL_X, WALL_Y
    );
endinterface

// File: rtl/maze_move_engine.sv
// Maze player-movement engine: key decode, wall-map check, steps, win and pulses.
// Optional undo history is enabled by defining MAZE_UNDO_EN.
module maze_move_engine #(
    parameter int COORD_W    = 6,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int START_X    = 1,
    parameter int START_Y    = 1,
    parameter int GOAL_X     = 38,
    parameter int GOAL_Y     = 28,
    parameter int STEP_W     = 16,
    parameter int UNDO_DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    maze_move_engine_if.slave  bus,
    output logic [COORD_W-1:0] BALL_X,
    output logic [COORD_W-1:0] BALL_Y,
    output logic [STEP_W-1:0]  STEPS,
    output logic               WIN,
    output logic               BUSY,
    output logic               CLICK,
    output logic               BUMP
);
    typedef enum logic [1:0] {IDLE, REQ, CHK, WON} state_t;

    localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] GX = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GY = COORD_W'(GOAL_Y);
    localparam logic signed [COORD_W:0] GW_S = (COORD_W+1)'(GRID_W);
    localparam logic signed [COORD_W:0] GH_S = (COORD_W+1)'(GRID_H);
    localparam logic signed [COORD_W:0] P1 = (COORD_W+1)'(1);
    localparam bit START_WON = (START_X == GOAL_X) && (START_Y == GOAL_Y);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [7:0] K_W  = 8'h1D;
    localparam logic [7:0] K_S  = 8'h1B;
    localparam logic [7:0] K_A  = 8'h1C;
    localparam logic [7:0] K_D  = 8'h23;
    localparam logic [7:0] K_R  = 8'h2D;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic               win_q, win_d;
    logic               click_q, click_d;
    logic               bump_q, bump_d;

    logic                      is_dir, in_range, restart;
    logic signed [COORD_W:0]   dx, dy, nx, ny;

`ifdef MAZE_UNDO_EN
    localparam int PW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
    localparam int CW = $clog2(UNDO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(UNDO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(UNDO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0] K_BS = 8'h66;

    logic [COORD_W-1:0] hx_q [UNDO_DEPTH];
    logic [COORD_W-1:0] hx_d [UNDO_DEPTH];
    logic [COORD_W-1:0] hy_q [UNDO_DEPTH];
    logic [COORD_W-1:0] hy_d [UNDO_DEPTH];
    logic [PW-1:0]      hp_q, hp_d, hp_prev;
    logic [CW-1:0]      hc_q, hc_d;

    // hp_q is the next write slot; full history overwrites the oldest entry
    assign hp_prev = (hp_q == '0) ? PTR_LAST : hp_q - PTR_ONE;
`else
    localparam int unused_undo_depth = UNDO_DEPTH;
`endif

    always_comb begin
        is_dir = 1'b0;
        dx     = '0;
        dy     = '0;
        case (bus.KEY_CODE)
            K_W: begin is_dir = 1'b1; dy = -P1; end
            K_S: begin is_dir = 1'b1; dy = P1;  end
            K_A: begin is_dir = 1'b1; dx = -P1; end
            K_D: begin is_dir = 1'b1; dx = P1;  end
            default: ;
        endcase
        nx = $signed({1'b0, bx_q}) + dx;
        ny = $signed({1'b0, by_q}) + dy;
        in_range = !nx[COORD_W] && (nx < GW_S) &&
                   !ny[COORD_W] && (ny < GH_S);
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        steps_d = steps_q;
        click_d = 1'b0;
        bump_d  = 1'b0;
        restart = 1'b0;
`ifdef MAZE_UNDO_EN
        hx_d = hx_q;
        hy_d = hy_q;
        hp_d = hp_q;
        hc_d = hc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.KEY_STB) begin
                    if (is_dir) begin
                        if (in_range) begin
                            tx_d    = nx[COORD_W-1:0];
                            ty_d    = ny[COORD_W-1:0];
                            state_d = REQ;
                        end else begin
                            bump_d = 1'b1;
                        end
                    end else if (bus.KEY_CODE == K_R) begin
                        restart = 1'b1;
`ifdef MAZE_UNDO_EN
                    end else if (bus.KEY_CODE == K_BS) begin
                        if (hc_q == '0) begin
                            bump_d = 1'b1;
                        end else begin
                            bx_d    = hx_q[hp_prev];
                            by_d    = hy_q[hp_prev];
                            hp_d    = hp_prev;
                            hc_d    = hc_q - CNT_ONE;
                            click_d = 1'b1;
                            if (steps_q != '0)
                                steps_d = steps_q - STEP_ONE;
                        end
`endif
                    end
                end
            end
            REQ: state_d = CHK;
            CHK: begin
                if (bus.WALL_Q) begin
                    bump_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    bx_d    = tx_q;
                    by_d    = ty_q;
                    click_d = 1'b1;
                    if (steps_q != STEP_MAX)
                        steps_d = steps_q + STEP_ONE;
`ifdef MAZE_UNDO_EN
                    hx_d[hp_q] = bx_q;
                    hy_d[hp_q] = by_q;
                    hp_d = (hp_q == PTR_LAST) ? '0 : hp_q + PTR_ONE;
                    if (hc_q != CNT_FULL)
                        hc_d = hc_q + CNT_ONE;
`endif
                    state_d = (tx_q == GX && ty_q == GY) ? WON : IDLE;
                end
            end
            WON: begin
                if (bus.KEY_STB && bus.KEY_CODE == K_R)
                    restart = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            bx_d    = SX;
            by_d    = SY;
            steps_d = '0;
            state_d = START_WON ? WON : IDLE;
`ifdef MAZE_UNDO_EN
            hp_d = '0;
            hc_d = '0;
`endif
        end
        // WIN tracks the ball position it is registered alongside
        win_d = (bx_d == GX) && (by_d == GY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= START_WON ? WON : IDLE;
            bx_q    <= SX;
            by_q    <= SY;
            tx_q    <= SX;
            ty_q    <= SY;
            steps_q <= '0;
            win_q   <= START_WON;
            click_q <= 1'b0;
            bump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            steps_q <= steps_d;
            win_q   <= win_d;
            click_q <= click_d;
            bump_q  <= bump_d;
        end
    end

`ifdef MAZE_UNDO_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hp_q <= '0;
            hc_q <= '0;
        end else begin
            hp_q <= hp_d;
            hc_q <= hc_d;
        end
    end

    always_ff @(posedge CLK) begin
        hx_q <= hx_d;
        hy_q <= hy_d;
    end
`endif

    assign bus.WALL_X = tx_q;
    assign bus.WALL_Y = ty_q;
    assign BALL_X     = bx_q;
    assign BALL_Y     = by_q;
    assign STEPS      = steps_q;
    assign WIN        = win_q;
    assign BUSY       = (state_q == REQ) || (state_q == CHK);
    assign CLICK      = click_q;
    assign BUMP       = bump_q;
endmodule
